booth_mult_arbiter: RTL and testbench

- Shares one iterative radix-2 Booth signed multiplier between NREQ requesters.
- Round-robin grant; accepts one operand pair, runs one Booth step per clock for WIDTH clocks, then presents the 2*WIDTH-bit product with the winning requester's ID.
- Sits between the per-unit operand producers and the result return path of the multiplier subsystem. Replaces the fully combinational multiplier wherever area beats latency.

---
 rtl/booth_pkg.sv | 27 ++
 rtl/booth_step.sv | 34 +++
 rtl/booth_mult_arbiter.sv | 108 ++++++++++
 tb/tb_booth_mult_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared constants and encodings for the iterative Booth multiplier arbiter.
// Holds the FSM state codes, the Booth step opcodes and the default sizes.
package booth_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_NREQ  = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        OP_NOP = 2'd0,
        OP_ADD = 2'd1,
        OP_SUB = 2'd2
    } booth_op_e;

    // Radix-2 Booth recoding of the multiplier bit pair {A[0], q_minus}.
    function automatic booth_op_e booth_decode(input logic a0, input logic qm);
        case ({a0, qm})
            2'b10:   return OP_SUB;
            2'b01:   return OP_ADD;
            default: return OP_NOP;
        endcase
    endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational radix-2 Booth step: add/subtract M into the high part,
// then arithmetic-shift the whole {high, low} accumulator right by one.
module booth_step
    import booth_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [2*WIDTH:0]  acc,
    input  logic              q_minus,
    input  logic [WIDTH-1:0]  m,
    output logic [2*WIDTH:0]  acc_next,
    output logic              q_minus_next
);

    logic [WIDTH:0] high;
    logic [WIDTH:0] m_ext;
    logic [WIDTH:0] high_new;
    booth_op_e      op;

    // The high part is one bit wider than M so that M = -2^(WIDTH-1) cannot overflow.
    always_comb begin
        high  = acc[2*WIDTH:WIDTH];
        m_ext = {m[WIDTH-1], m};
        op    = booth_decode(acc[0], q_minus);
        case (op)
            OP_ADD:  high_new = high + m_ext;
            OP_SUB:  high_new = high - m_ext;
            default: high_new = high;
        endcase
        acc_next     = {high_new[WIDTH], high_new, acc[WIDTH-1:1]};
        q_minus_next = acc[0];
    end

endmodule

// File: rtl/booth_mult_arbiter.sv
// Round-robin arbiter sharing one iterative radix-2 Booth signed multiplier
// between NREQ requesters; one Booth step per clock, product held until taken.
module booth_mult_arbiter
    import booth_pkg::*;
#(
    parameter  int NREQ  = DEF_NREQ,
    parameter  int WIDTH = DEF_WIDTH,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*WIDTH-1:0]   req_m,
    input  logic [NREQ*WIDTH-1:0]   req_q,
    output logic [NREQ-1:0]         req_ready,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [IDW-1:0]          rsp_id,
    output logic [2*WIDTH-1:0]      rsp_product,
    output logic                    busy
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    logic [1:0]        state;
    logic [CW-1:0]     count;
    logic [IDW-1:0]    rr_ptr;
    logic [IDW-1:0]    id_reg;
    logic [WIDTH-1:0]  m_reg;
    logic [2*WIDTH:0]  acc;
    logic              q_minus;
    logic [2*WIDTH:0]  acc_next;
    logic              q_minus_next;
    logic [IDW-1:0]    grant;
    logic              any_valid;

    // Search upward from the slot after the last winner; the smallest offset wins.
    function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] valid,
                                               input logic [IDW-1:0]  ptr);
        logic [IDW-1:0] pick;
        logic [IDW:0]   idx;
        pick = '0;
        for (int off = NREQ; off >= 1; off--) begin
            idx = {1'b0, ptr} + (IDW+1)'(off);
            if (idx >= (IDW+1)'(NREQ)) idx = idx - (IDW+1)'(NREQ);
            if (valid[idx[IDW-1:0]]) pick = idx[IDW-1:0];
        end
        return pick;
    endfunction

    assign any_valid = |req_valid;
    assign grant     = rr_pick(req_valid, rr_ptr);

    always_comb begin
        req_ready = '0;
        if (rst_n && state == ST_IDLE && any_valid) req_ready[grant] = 1'b1;
    end

    booth_step #(.WIDTH(WIDTH)) u_step (
        .acc          (acc),
        .q_minus      (q_minus),
        .m            (m_reg),
        .acc_next     (acc_next),
        .q_minus_next (q_minus_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            count   <= '0;
            rr_ptr  <= IDW'(NREQ-1);
            id_reg  <= '0;
            m_reg   <= '0;
            acc     <= '0;
            q_minus <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_valid) begin
                        m_reg   <= req_m[int'(grant)*WIDTH +: WIDTH];
                        acc     <= {{(WIDTH+1){1'b0}}, req_q[int'(grant)*WIDTH +: WIDTH]};
                        q_minus <= 1'b0;
                        id_reg  <= grant;
                        rr_ptr  <= grant;
                        count   <= '0;
                        state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc     <= acc_next;
                    q_minus <= q_minus_next;
                    if (count == CW'(WIDTH-1)) state <= ST_DONE;
                    else                       count <= count + 1'b1;
                end
                ST_DONE: begin
                    if (rsp_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign rsp_valid   = (state == ST_DONE);
    assign rsp_product = rsp_valid ? acc[2*WIDTH-1:0] : '0;
    assign rsp_id      = rsp_valid ? id_reg : '0;
    assign busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Self-checking bench for booth_mult_arbiter: a transaction-level reference model
// checked every cycle, plus directed vectors with hand-computed products.
module tb_booth_mult_arbiter;

    localparam int N   = 4;
    localparam int W   = 32;
    localparam int IDW = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [N-1:0]       req_valid;
    logic [N*W-1:0]     req_m;
    logic [N*W-1:0]     req_q;
    logic [N-1:0]       req_ready;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [2*W-1:0]     rsp_product;
    logic               busy;

    int nvec = 0;
    int nerr = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    booth_mult_arbiter #(.NREQ(N), .WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_m       (req_m),
        .req_q       (req_q),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_product (rsp_product),
        .busy        (busy)
    );

    // Transaction-level model: who wins next, the exact product, and how long until it shows.
    typedef enum int {MD_WAIT, MD_CALC, MD_HOLD} md_phase_e;
    md_phase_e          md_phase;
    int                 md_left;
    int                 md_ptr;
    logic [IDW-1:0]     md_id;
    logic signed [63:0] md_prod;

    function automatic int pickNext(input logic [N-1:0] v, input int ptr);
        int idx;
        for (int k = 1; k <= N; k++) begin
            idx = (ptr + k) % N;
            if (v[idx[IDW-1:0]]) return idx;
        end
        return -1;
    endfunction

    function automatic logic signed [63:0] refMul(input logic [31:0] a, input logic [31:0] b);
        longint x;
        longint y;
        x = longint'($signed(a));
        y = longint'($signed(b));
        return x * y;
    endfunction

    always @(posedge clk or negedge rst_n) begin : model_update
        int g;
        if (!rst_n) begin
            md_phase <= MD_WAIT;
            md_left  <= 0;
            md_ptr   <= N-1;
            md_id    <= '0;
            md_prod  <= '0;
        end else begin
            case (md_phase)
                MD_WAIT: begin
                    g = pickNext(req_valid, md_ptr);
                    if (g >= 0) begin
                        md_prod  <= refMul(req_m[g*W +: W], req_q[g*W +: W]);
                        md_id    <= IDW'(g);
                        md_ptr   <= g;
                        md_left  <= W;
                        md_phase <= MD_CALC;
                    end
                end
                MD_CALC: begin
                    md_left <= md_left - 1;
                    if (md_left == 1) md_phase <= MD_HOLD;
                end
                MD_HOLD: if (rsp_ready) md_phase <= MD_WAIT;
                default: md_phase <= MD_WAIT;
            endcase
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : compare
        int g;
        logic [N-1:0] exp_ready;
        if (chk_en) begin
            exp_ready = '0;
            if (rst_n && md_phase == MD_WAIT) begin
                g = pickNext(req_valid, md_ptr);
                if (g >= 0) exp_ready[g[IDW-1:0]] = 1'b1;
            end
            checkOutput("req_ready", 64'(req_ready), 64'(exp_ready));
            checkOutput("rsp_valid", 64'(rsp_valid), 64'(md_phase == MD_HOLD));
            checkOutput("busy", 64'(busy), 64'(md_phase != MD_WAIT));
            checkOutput("rsp_product", rsp_product, (md_phase == MD_HOLD) ? md_prod : 64'd0);
            checkOutput("rsp_id", 64'(rsp_id), (md_phase == MD_HOLD) ? 64'(md_id) : 64'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int id, input logic [31:0] m, input logic [31:0] q);
        req_m[id*W +: W] = m;
        req_q[id*W +: W] = q;
        req_valid[id]    = 1'b1;
    endtask

    // Returns at 1ns after the edge that accepted requester id.
    task automatic waitGrant(input int id, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            if (req_ready[id[IDW-1:0]] && req_valid[id[IDW-1:0]]) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            nvec++;
            nerr++;
            $display("[TB] FAIL grant_timeout: requester %0d got no grant in 200 cycles", id);
        end
    endtask

    // Counts clock edges after the accept edge until rsp_valid is seen.
    task automatic waitResp(output bit ok, output int edges);
        ok    = 1'b0;
        edges = 0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            nvec++;
            nerr++;
            $display("[TB] FAIL resp_timeout: no rsp_valid within 200 cycles");
        end
    endtask

    task automatic runOp(input int id, input logic [31:0] m, input logic [31:0] q,
                         output logic [63:0] p, output int rid);
        bit ok;
        int edges;
        applyStimulus(id, m, q);
        waitGrant(id, ok);
        req_valid[id] = 1'b0;
        waitResp(ok, edges);
        p   = rsp_product;
        rid = int'(rsp_id);
        tick();
    endtask

    task automatic waitIdle();
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            if (!busy) ok = 1'b1;
        end
        if (!ok) begin
            nvec++;
            nerr++;
            $display("[TB] FAIL idle_timeout: busy never dropped");
        end
        tick();
    endtask

    function automatic logic [31:0] randOperand();
        case ($urandom_range(0, 7))
            0:       return 32'h8000_0000;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h0000_0000;
            3:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin : main
        bit            ok;
        int            edges;
        logic [63:0]   p;
        int            rid;
        int            order[$];
        int            exp_order[5];
        logic [N-1:0]  accepted;
        int            completed;

        rst_n     = 1'b0;
        req_valid = '0;
        req_m     = '0;
        req_q     = '0;
        rsp_ready = 1'b1;

        // Reset values
        @(posedge clk);
        @(negedge clk);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("reset_req_ready", 64'(req_ready), 64'd0);
        checkOutput("reset_rsp_product", rsp_product, 64'd0);
        checkOutput("reset_rsp_id", 64'(rsp_id), 64'd0);
        @(posedge clk);
        #3;
        rst_n  = 1'b1;
        chk_en = 1'b1;
        tick();

        // Single request from requester 2: 7 * -3
        applyStimulus(2, 32'd7, -32'sd3);
        @(negedge clk);
        checkOutput("single_ready", 64'(req_ready), 64'b0100);
        tick();
        req_valid[2] = 1'b0;
        @(negedge clk);
        checkOutput("single_ready_drop", 64'(req_ready), 64'd0);
        waitResp(ok, edges);
        checkOutput("single_latency_edges", 64'(edges), 64'd32);
        checkOutput("single_product", rsp_product, 64'hFFFF_FFFF_FFFF_FFEB);
        checkOutput("single_id", 64'(rsp_id), 64'd2);
        tick();

        // Corner operands
        runOp(0, 32'h8000_0000, 32'h8000_0000, p, rid);
        checkOutput("corner_minmin", p, 64'h4000_0000_0000_0000);
        checkOutput("corner_minmin_id", 64'(rid), 64'd0);
        runOp(1, 32'h8000_0000, 32'h0000_0001, p, rid);
        checkOutput("corner_min_one", p, 64'hFFFF_FFFF_8000_0000);
        runOp(3, 32'h0000_0000, 32'h1234_5678, p, rid);
        checkOutput("corner_zero", p, 64'd0);
        runOp(2, 32'h7FFF_FFFF, 32'h8000_0000, p, rid);
        checkOutput("corner_max_min", p, 64'hC000_0000_8000_0000);

        // Round robin with all four requesters held valid from reset
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < N; i++) applyStimulus(i, 32'(i + 10), -32'(i + 1));
        exp_order = '{0, 1, 2, 3, 0};
        for (int c = 0; c < 400 && order.size() < 5; c++) begin
            @(negedge clk);
            if (req_ready != '0) order.push_back($clog2(req_ready));
            @(posedge clk);
            #1;
            if (order.size() == 5) req_valid = '0;
        end
        checkOutput("rr_grant_count", 64'(order.size()), 64'd5);
        for (int k = 0; k < 5 && k < order.size(); k++)
            checkOutput("rr_grant_order", 64'(order[k]), 64'(exp_order[k]));
        waitIdle();

        // Backpressure: hold the product for 10 cycles with a second request pending
        rsp_ready = 1'b0;
        applyStimulus(1, -32'sd100, 32'sd250);
        applyStimulus(3, 32'd5, 32'd6);
        waitGrant(1, ok);
        req_valid[1] = 1'b0;
        waitResp(ok, edges);
        checkOutput("bp_product", rsp_product, -64'sd25000);
        checkOutput("bp_id", 64'(rsp_id), 64'd1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checkOutput("bp_hold_product", rsp_product, -64'sd25000);
            checkOutput("bp_hold_id", 64'(rsp_id), 64'd1);
            checkOutput("bp_hold_no_grant", 64'(req_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("bp_release_valid", 64'(rsp_valid), 64'd0);
        checkOutput("bp_release_grant", 64'(req_ready), 64'b1000);
        tick();
        req_valid[3] = 1'b0;
        waitResp(ok, edges);
        checkOutput("bp_next_product", rsp_product, 64'd30);
        checkOutput("bp_next_id", 64'(rsp_id), 64'd3);
        tick();

        // Async reset in the middle of RUN discards the operation
        applyStimulus(2, 32'd1234, 32'd5678);
        waitGrant(2, ok);
        req_valid[2] = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        applyStimulus(0, 32'd11, 32'd13);
        applyStimulus(3, 32'd17, 32'd19);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("abort_req_ready", 64'(req_ready), 64'd0);
        checkOutput("abort_rsp_product", rsp_product, 64'd0);
        checkOutput("abort_rsp_id", 64'(rsp_id), 64'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("abort_first_grant", 64'(req_ready), 64'b0001);
        tick();
        req_valid[0] = 1'b0;
        waitResp(ok, edges);
        checkOutput("abort_next_product", rsp_product, 64'd143);
        checkOutput("abort_next_id", 64'(rsp_id), 64'd0);
        tick();
        waitGrant(3, ok);
        req_valid[3] = 1'b0;
        waitResp(ok, edges);
        checkOutput("abort_second_product", rsp_product, 64'd323);
        checkOutput("abort_second_id", 64'(rsp_id), 64'd3);
        tick();

        // Random traffic, random backpressure, occasional withdrawn requests
        completed = 0;
        for (int cyc = 0; cyc < 20000 && completed < 300; cyc++) begin
            @(negedge clk);
            accepted = req_valid & req_ready;
            if (rsp_valid && rsp_ready) completed++;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (accepted[i]) req_valid[i] = 1'b0;
                else if (!req_valid[i] && $urandom_range(0, 3) == 0)
                    applyStimulus(i, randOperand(), randOperand());
                else if (req_valid[i] && $urandom_range(0, 15) == 0)
                    req_valid[i] = 1'b0;
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        checkOutput("random_completed", 64'(completed), 64'd300);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
